// File: rtl/seq_signed_divider.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU unit: restoring shift-subtract on magnitudes.
// Define DIV_EARLY_OUT_EN to skip the loop for divide-by-zero and |a| < |b|.
module seq_signed_divider #(
  parameter int NUM_SIZE = 32
) (
  input  logic                clk,
  input  logic                rstN,
  input  logic                inValid,
  output logic                inReady,
  input  logic [NUM_SIZE-1:0] dIn0,
  input  logic [NUM_SIZE-1:0] dIn1,
  input  logic                isSigned,
  output logic                outValid,
  input  logic                outReady,
  output logic [NUM_SIZE-1:0] quotient,
  output logic [NUM_SIZE-1:0] remainder
);

  localparam int CW = $clog2(NUM_SIZE);

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    DIVIDE,
    FIXUP,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [NUM_SIZE-1:0] a_in, b_in;
  logic                sgn;
  logic [NUM_SIZE-1:0] a_sh, b_mag, rem;
  logic                neg_a, neg_b, div_zero;
  logic [CW-1:0]       cnt;

  logic                na, nb, bz, early, fits;
  logic [NUM_SIZE-1:0] a_abs, b_abs;
  logic [NUM_SIZE:0]   shifted, diff;

  assign na    = sgn & a_in[NUM_SIZE-1];
  assign nb    = sgn & b_in[NUM_SIZE-1];
  assign a_abs = na ? (~a_in + 1'b1) : a_in;
  assign b_abs = nb ? (~b_in + 1'b1) : b_in;
  assign bz    = (b_in == '0);

`ifdef DIV_EARLY_OUT_EN
  assign early = bz | (a_abs < b_abs);
`else
  assign early = 1'b0;
`endif

  // a_sh shifts dividend bits out the top and quotient bits in the bottom
  assign shifted = {rem, a_sh[NUM_SIZE-1]};
  assign diff    = shifted - {1'b0, b_mag};
  assign fits    = ~diff[NUM_SIZE];

  assign inReady  = (state == IDLE);
  assign outValid = (state == DONE);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:   if (inValid) state_nx = PREP;
      PREP:   state_nx = early ? FIXUP : DIVIDE;
      DIVIDE: if (cnt == '0) state_nx = FIXUP;
      FIXUP:  state_nx = DONE;
      DONE:   if (outReady) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      a_in      <= '0;
      b_in      <= '0;
      sgn       <= 1'b0;
      a_sh      <= '0;
      b_mag     <= '0;
      rem       <= '0;
      neg_a     <= 1'b0;
      neg_b     <= 1'b0;
      div_zero  <= 1'b0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (inValid) begin
            a_in <= dIn0;
            b_in <= dIn1;
            sgn  <= isSigned;
          end
        end
        PREP: begin
          neg_a    <= na;
          neg_b    <= nb;
          div_zero <= bz;
          b_mag    <= b_abs;
          cnt      <= CW'(NUM_SIZE - 1);
          if (early) begin
            a_sh <= bz ? '1 : '0;
            rem  <= a_abs;
          end else begin
            a_sh <= a_abs;
            rem  <= '0;
          end
        end
        DIVIDE: begin
          rem  <= fits ? diff[NUM_SIZE-1:0] : shifted[NUM_SIZE-1:0];
          a_sh <= {a_sh[NUM_SIZE-2:0], fits};
          cnt  <= cnt - 1'b1;
        end
        FIXUP: begin
          if (div_zero)
            quotient <= '1;
          else
            quotient <= (neg_a ^ neg_b) ? (~a_sh + 1'b1) : a_sh;
          remainder <= neg_a ? (~rem + 1'b1) : rem;
        end
        default: ;
      endcase
    end
  end

endmodule
